// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// and driving datapath enables, mux selects and the ALU f code.
module mips_mc_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   localparam logic [3:0] FETCH   = 4'd0;
   localparam logic [3:0] DECODE  = 4'd1;
   localparam logic [3:0] MEMADR  = 4'd2;
   localparam logic [3:0] MEMRD   = 4'd3;
   localparam logic [3:0] MEMWB   = 4'd4;
   localparam logic [3:0] MEMWR   = 4'd5;
   localparam logic [3:0] RTYPEEX = 4'd6;
   localparam logic [3:0] RTYPEWB = 4'd7;
   localparam logic [3:0] BEQEX   = 4'd8;
   localparam logic [3:0] ADDIEX  = 4'd9;
   localparam logic [3:0] ADDIWB  = 4'd10;
   localparam logic [3:0] JEX     = 4'd11;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic [3:0] state_d;
   logic [1:0] aluop;
   logic       pcwrite, branch;
   logic       irwrite_s, memwrite_s, regwrite_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      unique case (state)
         FETCH:   state_d = DECODE;
         DECODE: begin
            unique case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYP:      state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = MEMWB;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      irwrite_s  = 1'b0;
      memwrite_s = 1'b0;
      regwrite_s = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = 2'b00;
      unique case (state)
         FETCH: begin
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
            alusrcb   = 2'b01;
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg   = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWB: begin
            regwrite_s = 1'b1;
            regdst     = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            branch  = 1'b1;
            pcsrc   = 2'b01;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB:  regwrite_s = 1'b1;
         JEX: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
         end
         default: ;
      endcase
   end

   always_comb begin
      alucontrol = 3'b010;
      if (aluop == 2'b01) begin
         alucontrol = 3'b110;
      end else if (aluop == 2'b10) begin
         unique case (funct)
            6'b100010: alucontrol = 3'b110;
            6'b100100: alucontrol = 3'b000;
            6'b100101: alucontrol = 3'b001;
            6'b101010: alucontrol = 3'b111;
            default:   alucontrol = 3'b010;
         endcase
      end
   end

   // Write enables are gated by reset so an aborted instruction cannot commit.
   assign pcen     = rst_n & (pcwrite | (branch & zero));
   assign irwrite  = rst_n & irwrite_s;
   assign memwrite = rst_n & memwrite_s;
   assign regwrite = rst_n & regwrite_s;

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the MIPS core: drives the datapath's register enables, mux selects and the 3-bit ALU function code `f` consumed by the existing ALU. It decodes `op` and `funct` from the instruction register and sequences each instruction through a Moore FSM. It replaces the single-cycle combinational decoder when the core runs one shared ALU and one unified memory.

## Interface

- No parameters; opcode and funct encodings are fixed by the MIPS ISA.
- `clk` input 1: system clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 6: `instr[31:26]` from the instruction register.
- `funct` input 6: `instr[5:0]` from the instruction register.
- `zero` input 1: ALU zero flag.
- `pcen` output 1: PC write enable, equal to `pcwrite | (branch & zero)`.
- `irwrite` output 1: instruction register load.
- `memwrite` output 1: memory write.
- `regwrite` output 1: register file write.
- `iord` output 1: memory address select, 0 = PC, 1 = ALUOut.
- `regdst` output 1: write register select, 0 = rt, 1 = rd.
- `memtoreg` output 1: writeback source select, 0 = ALUOut, 1 = data register.
- `alusrca` output 1: ALU A select, 0 = PC, 1 = register A.
- `alusrcb` output 2: ALU B select. 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- `pcsrc` output 2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` output 3: ALU `f` code.
- `state` output 4: current FSM state, for debug.

## Operation

- **States, in 4-bit encoding:**
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR
  - 6 RTYPEEX, 7 RTYPEWB, 8 BEQEX, 9 ADDIEX, 10 ADDIWB, 11 JEX
  - Encodings 12–15 are unreachable and return to FETCH.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE, by `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 → RTYPEEX
    - 000100 (beq) → BEQEX
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JEX
    - any other `op` → FETCH. The instruction is treated as a NOP and the PC has already advanced.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB, then MEMWB→FETCH.
  - MEMWR→FETCH.
  - RTYPEEX→RTYPEWB, then RTYPEWB→FETCH.
  - ADDIEX→ADDIWB, then ADDIWB→FETCH.
  - BEQEX→FETCH and JEX→FETCH.
- **Moore outputs.** Every signal not listed for a state is 0.
  - FETCH: `irwrite=1`, `pcwrite=1`, `alusrcb=01`, aluop=00.
  - DECODE: `alusrcb=11`, aluop=00.
  - MEMADR: `alusrca=1`, `alusrcb=10`, aluop=00.
  - MEMRD: `iord=1`.
  - MEMWB: `regwrite=1`, `memtoreg=1`.
  - MEMWR: `iord=1`, `memwrite=1`.
  - RTYPEEX: `alusrca=1`, aluop=10.
  - RTYPEWB: `regwrite=1`, `regdst=1`.
  - BEQEX: `alusrca=1`, aluop=01, `branch=1`, `pcsrc=01`.
  - ADDIEX: `alusrca=1`, `alusrcb=10`, aluop=00.
  - ADDIWB: `regwrite=1`.
  - JEX: `pcwrite=1`, `pcsrc=10`.
- **ALU decode** (combinational, from internal aluop and `funct`):
  - aluop 00 → 010 (add); aluop 01 → 110 (sub).
  - aluop 10, by `funct`:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111 (slt)
    - any other `funct` → 010
  - aluop 11 is unused and maps to 010.
- **`pcen`** is combinational; `zero` is sampled in BEQEX only.

## Timing

- State register updates on the rising edge of `clk`. Asynchronous clear on the falling edge of `rst_n` forces state to FETCH.
- **During reset** (`rst_n`=0):
  - State is held at FETCH.
  - `pcen`, `irwrite`, `memwrite` and `regwrite` are forced to 0 combinationally.
  - All other outputs show their FETCH values: `alusrcb=01`, `alucontrol=010`, rest 0.
- The first rising edge with `rst_n`=1 completes a FETCH.
- **Cycles per instruction, including FETCH:**
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal `op` 2.
- All outputs are valid combinationally within the state cycle.
- `op` and `funct` must be stable from the DECODE cycle onward. The instruction register updates only at the end of FETCH, which guarantees this.
- Reset asserted mid-instruction aborts it immediately:
  - no further writes occur;
  - after release, execution resumes at FETCH.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 edges, then release.
  - During reset: `state`=0, `pcen`=`irwrite`=`regwrite`=`memwrite`=0, `alucontrol`=010.
  - After the first edge following release: `state`=1.
- **lw:** `op`=100011.
  - State sequence 0,1,2,3,4,0.
  - `iord`=1 in state 3; `regwrite`=`memtoreg`=1 in state 4.
  - `memwrite` stays 0 throughout.
- **R-type:** `op`=000000; run once each with `funct`=100010, 101010, 111111.
  - `alucontrol` in state 6 is 110, 111 and 010 respectively.
  - In state 7: `regwrite`=`regdst`=1.
- **beq:** `op`=000100, run twice.
  - With `zero`=1: `pcen`=1 in state 8.
  - With `zero`=0: `pcen`=0 in state 8.
  - `alucontrol`=110 in state 8 in both runs.
- **sw, j, illegal opcode:**
  - sw (`op`=101011): sequence 0,1,2,5,0, with `memwrite`=1 only in state 5.
  - j (`op`=000010): `pcsrc`=10 and `pcen`=1 in state 11.
  - `op`=111111: sequence 0,1,0, with no `regwrite` or `memwrite`.
- **Mid-instruction reset:** assert `rst_n`=0 asynchronously (not on a clock edge) while in state 3 of an lw.
  - `state` goes to 0 immediately.
  - `regwrite` never pulses.
  - After release the sequence restarts at 0,1.
